// File: rtl/sram_pkg.sv
// sram_pkg: shared SRAM port widths, write request type and scratch address
package sram_pkg;
    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;
    // Scratch word that idle write slots target; the memory map keeps it reserved
    localparam logic [SRAM_ADDR_W-1:0] SRAM_DUMMY_ADDR = 20'hFFFFF;

    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
    } sram_wr_req_t;
endpackage

// File: rtl/sram_frame_client_if.sv
// sram_frame_client_if: requester-side handshakes plus the SRAM port signals
interface sram_frame_client_if;
    import sram_pkg::*;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [SRAM_ADDR_W-1:0] wr_addr;
    logic [SRAM_DATA_W-1:0] wr_data;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [SRAM_ADDR_W-1:0] rd_addr;
    logic                   rd_resp_valid;
    logic [SRAM_DATA_W-1:0] rd_resp_data;
    logic                   wfifo_empty;
    logic                   Read_ready;
    logic [SRAM_DATA_W-1:0] Data_read;
    logic [SRAM_ADDR_W-1:0] Read_ADDR;
    logic [SRAM_ADDR_W-1:0] Write_ADDR;
    logic [SRAM_DATA_W-1:0] Data_write;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, Read_ready, Data_read,
        output wr_ready, rd_ready, rd_resp_valid, rd_resp_data, wfifo_empty,
               Read_ADDR, Write_ADDR, Data_write
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, Read_ready, Data_read,
        input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data, wfifo_empty,
               Read_ADDR, Write_ADDR, Data_write
    );
endinterface

// File: rtl/sram_wr_fifo.sv
// sram_wr_fifo: small synchronous queue of pending SRAM writes
module sram_wr_fifo
    import sram_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  sram_wr_req_t din,
    output sram_wr_req_t dout,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);
    sram_wr_req_t  mem_q [DEPTH];
    sram_wr_req_t  mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign dout    = mem_q[rptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next storage, pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wptr_q] = din;
        wptr_d  = wptr_q + PW'(push_ok);
        rptr_d  = rptr_q + PW'(pop_ok);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Queue state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/sram_frame_client.sv
// sram_frame_client: aligns queued writes and single reads to the SRAM port's slot rhythm
module sram_frame_client
    import sram_pkg::*;
#(
    parameter int                     WFIFO_DEPTH = 4,
    parameter logic [SRAM_ADDR_W-1:0] DUMMY_ADDR  = SRAM_DUMMY_ADDR
) (
    input logic                Clk,
    input logic                Reset_h,
    sram_frame_client_if.slave bus
);
    localparam int CW = $clog2(WFIFO_DEPTH) + 1;

    logic                   load, push, pop, accept;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count;
    sram_wr_req_t           fifo_head, wr_in, idle_req;
    sram_wr_req_t           wr_slot_q, wr_slot_d;
    logic [SRAM_ADDR_W-1:0] read_addr_q, read_addr_d;
    logic                   rd_pending_q, rd_pending_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [SRAM_DATA_W-1:0] resp_data_q, resp_data_d;

    // A load edge is any edge where the port is in its write slot
    assign load     = bus.Read_ready;
    assign bus.wr_ready = !fifo_full && !Reset_h;
    assign bus.rd_ready = bus.Read_ready && !Reset_h;
    assign push     = bus.wr_valid && bus.wr_ready;
    assign pop      = load && !fifo_empty;
    assign accept   = bus.rd_valid && bus.rd_ready;
    assign wr_in    = '{addr: bus.wr_addr, data: bus.wr_data};
    assign idle_req = '{addr: DUMMY_ADDR, data: '0};

    sram_wr_fifo #(.DEPTH(WFIFO_DEPTH)) u_wr_fifo (
        .clk   (Clk),
        .rst   (Reset_h),
        .push  (push),
        .pop   (pop),
        .din   (wr_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Port-facing registers change only on load edges; the response pulse self-clears otherwise
    always_comb begin
        wr_slot_d    = load ? (fifo_empty ? idle_req : fifo_head) : wr_slot_q;
        read_addr_d  = accept ? bus.rd_addr : read_addr_q;
        rd_pending_d = load ? accept : rd_pending_q;
        resp_valid_d = load && rd_pending_q;
        resp_data_d  = load ? bus.Data_read : resp_data_q;
    end

    // Slot, read-tracking and response registers
    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            wr_slot_q    <= '{addr: DUMMY_ADDR, data: '0};
            read_addr_q  <= '0;
            rd_pending_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            wr_slot_q    <= wr_slot_d;
            read_addr_q  <= read_addr_d;
            rd_pending_q <= rd_pending_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.Read_ADDR     = read_addr_q;
    assign bus.Write_ADDR    = wr_slot_q.addr;
    assign bus.Data_write    = wr_slot_q.data;
    assign bus.rd_resp_valid = resp_valid_q;
    assign bus.rd_resp_data  = resp_data_q;
    assign bus.wfifo_empty   = fifo_count == '0;
endmodule
